// File: rtl/tt_mux_pkg.sv
// Shared types and constants for the project-slot multiplexer: controller states,
// word widths and bit positions inside the shared input word.
package tt_mux_pkg;

    localparam int IW_W     = 18;
    localparam int OW_W     = 24;
    localparam int CLK_BIT  = 0;
    localparam int RSTN_BIT = 1;
    localparam int UI_LSB   = 2;
    localparam int UIO_LSB  = 10;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2,
        RUN   = 2'd3
    } mux_state_e;

    // Input word as seen by a project held in reset: only its rst_n bit is pulled low.
    function automatic logic [IW_W-1:0] hold_iw(input logic [IW_W-1:0] w);
        logic [IW_W-1:0] r;
        r           = w;
        r[RSTN_BIT] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/tt_mux_rst_timer.sv
// Down-counter that times the forced project reset after each activation.
module tt_mux_rst_timer
    import tt_mux_pkg::*;
#(
    parameter int RST_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count_en,
    output logic done
);

    logic [CNT_W-1:0] cnt_r;

    // Load RST_HOLD-1 so that done rises in the last of RST_HOLD counting cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= CNT_W'(RST_HOLD - 1);
        end else if (count_en && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/tt_mux_slot.sv
// Project-slot multiplexer: routes the shared input word to one selected project,
// forces a timed reset on every activation and returns that project's output word.
module tt_mux_slot
    import tt_mux_pkg::*;
#(
    parameter int NUM_PROJ = 4,
    parameter int RST_HOLD = 4,
    parameter int SEL_W    = $clog2(NUM_PROJ) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     sel_valid,
    output logic                     sel_ready,
    input  logic [IW_W-1:0]          iw,
    output logic [OW_W-1:0]          ow,
    output logic [NUM_PROJ*IW_W-1:0] proj_iw,
    input  logic [NUM_PROJ*OW_W-1:0] proj_ow,
    output logic [NUM_PROJ-1:0]      proj_ena,
    output logic [SEL_W-1:0]         active,
    output logic                     busy,
    output logic                     sel_err
);

    localparam logic [SEL_W-1:0] SEL_NONE  = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] SEL_LIMIT = SEL_W'(NUM_PROJ);

    mux_state_e                state_r;
    mux_state_e                state_nx_s;
    logic [SEL_W-1:0]          pending_r;
    logic [SEL_W-1:0]          active_r;
    logic                      sel_err_r;
    logic [OW_W-1:0]           ow_r;
    logic [OW_W-1:0]           ow_nx_s;
    logic                      accept_s;
    logic                      sel_ok_s;
    logic                      ready_s;
    logic                      busy_s;
    logic                      slot_on_s;
    logic                      hold_load_s;
    logic                      hold_cnt_en_s;
    logic                      hold_done_s;
    logic [NUM_PROJ-1:0]       ena_s;
    logic [NUM_PROJ*IW_W-1:0]  piw_s;

    assign sel_ok_s    = (sel < SEL_LIMIT);
    assign accept_s    = sel_valid & ready_s;
    assign hold_load_s = (state_nx_s == HOLD) && (state_r != HOLD);

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; an accepted select in RUN always drains first, even for the same slot.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && sel_ok_s) state_nx_s = HOLD;
                else                      state_nx_s = IDLE;
            end
            DRAIN: begin
                if (pending_r != SEL_NONE) state_nx_s = HOLD;
                else                       state_nx_s = IDLE;
            end
            HOLD: begin
                if (hold_done_s) state_nx_s = RUN;
                else             state_nx_s = HOLD;
            end
            RUN: begin
                if (accept_s) state_nx_s = DRAIN;
                else          state_nx_s = RUN;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State-decoded controls; a slot is only connected in HOLD and RUN.
    always_comb begin
        ready_s       = 1'b0;
        busy_s        = 1'b0;
        slot_on_s     = 1'b0;
        hold_cnt_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
            end
            DRAIN: begin
                busy_s = 1'b1;
            end
            HOLD: begin
                busy_s        = 1'b1;
                slot_on_s     = 1'b1;
                hold_cnt_en_s = 1'b1;
            end
            RUN: begin
                ready_s   = 1'b1;
                slot_on_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Pending/active slot bookkeeping and the sticky out-of-range flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= SEL_NONE;
            active_r  <= SEL_NONE;
            sel_err_r <= 1'b0;
        end else begin
            if (accept_s) pending_r <= sel_ok_s ? sel : SEL_NONE;
            else          pending_r <= pending_r;

            if (accept_s && !sel_ok_s) sel_err_r <= 1'b1;
            else                       sel_err_r <= sel_err_r;

            // From IDLE the request bypasses pending since both latch on the same edge.
            if (hold_load_s)           active_r <= (state_r == IDLE) ? sel : pending_r;
            else if (state_r == DRAIN) active_r <= SEL_NONE;
            else                       active_r <= active_r;
        end
    end

    tt_mux_rst_timer #(
        .RST_HOLD (RST_HOLD)
    ) u_rst_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load_s),
        .count_en (hold_cnt_en_s),
        .done     (hold_done_s)
    );

    // Route iw to the active slot only; combinational so the clock bit is not retimed.
    always_comb begin
        ena_s = {NUM_PROJ{1'b0}};
        piw_s = {(NUM_PROJ*IW_W){1'b0}};
        for (int k = 0; k < NUM_PROJ; k++) begin
            if (slot_on_s && (active_r == SEL_W'(k))) begin
                ena_s[k] = 1'b1;
                if (state_r == HOLD) piw_s[k*IW_W +: IW_W] = hold_iw(iw);
                else                 piw_s[k*IW_W +: IW_W] = iw;
            end else begin
                ena_s[k]               = 1'b0;
                piw_s[k*IW_W +: IW_W]  = {IW_W{1'b0}};
            end
        end
    end

    // Return path: only a running slot's output word is forwarded.
    always_comb begin
        ow_nx_s = {OW_W{1'b0}};
        for (int k = 0; k < NUM_PROJ; k++) begin
            ow_nx_s = ow_nx_s | (((state_r == RUN) && (active_r == SEL_W'(k)))
                                 ? proj_ow[k*OW_W +: OW_W] : {OW_W{1'b0}});
        end
    end

    // Output word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ow_r <= {OW_W{1'b0}};
        end else begin
            ow_r <= ow_nx_s;
        end
    end

    assign sel_ready = ready_s;
    assign busy      = busy_s;
    assign proj_ena  = ena_s;
    assign proj_iw   = piw_s;
    assign active    = active_r;
    assign sel_err   = sel_err_r;
    assign ow        = ow_r;

endmodule
